// File: rtl/ann_bram_pkg.sv
// rtl/ann_bram_pkg.sv - shared sizes, mode encoding and state type for the neuron weight BRAM sequencer
package ann_bram_pkg;

    localparam int DEF_DEPTH = 28;
    localparam int DEF_AW    = 5;
    localparam int DEF_DW    = 16;

    localparam logic MODE_FETCH = 1'b0;
    localparam logic MODE_LOAD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FETCH = 2'd2
    } seq_state_e;

endpackage

// File: rtl/weight_skid_fifo.sv
// rtl/weight_skid_fifo.sv - two-entry FIFO holding captured BRAM words for the MAC stream
module weight_skid_fifo #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = pop & (count_q != 2'd0);
    assign do_push = push & ((count_q != 2'd2) | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/weight_bram_seq.sv
// rtl/weight_bram_seq.sv - loads a neuron weight BRAM from a stream and fetches it back to the MAC
module weight_bram_seq
    import ann_bram_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          MODE,
    input  logic          LD_VALID,
    output logic          LD_READY,
    input  logic [DW-1:0] LD_DATA,
    output logic [AW-1:0] BRAM_ADDR,
    output logic [DW-1:0] BRAM_DI,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic [DW-1:0] W_DATA,
    output logic [AW-1:0] W_IDX,
    output logic          W_LAST,
    output logic          BUSY,
    output logic          DONE
);

    localparam int            EW        = DW + AW + 1;
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    seq_state_e    state_q, state_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic          bram_en_q, bram_en_d;
    logic          bram_we_q, bram_we_d;
    logic [AW-1:0] bram_addr_q, bram_addr_d;
    logic [DW-1:0] bram_di_q, bram_di_d;
    logic          done_q, done_d;

    logic          ld_hs;
    logic          fifo_push;
    logic          fifo_pop;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;
    logic [1:0]    fifo_cnt;
    logic [2:0]    occ_next;

    // A read issued last edge has its data on BRAM_DO now; its address is still on BRAM_ADDR.
    assign fifo_push  = bram_en_q & ~bram_we_q;
    assign push_entry = {bram_addr_q == ADDR_LAST, bram_addr_q, BRAM_DO};

    weight_skid_fifo #(
        .W(EW)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .count     (fifo_cnt)
    );

    assign W_VALID = (fifo_cnt != 2'd0);
    assign fifo_pop = W_VALID & W_READY;
    assign {W_LAST, W_IDX, W_DATA} = head_entry;

    assign LD_READY = (state_q == ST_LOAD) && (wr_cnt_q < CNT_DEPTH);
    assign ld_hs    = LD_READY & LD_VALID;
    assign BUSY     = (state_q != ST_IDLE);

    // Buffered words plus the read landing now; one more read fits only if this stays <= 1.
    assign occ_next = {1'b0, fifo_cnt} - {2'b00, fifo_pop} + {2'b00, fifo_push};

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        bram_en_d   = 1'b0;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_di_d   = bram_di_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (MODE == MODE_LOAD) begin
                        state_d  = ST_LOAD;
                        wr_cnt_d = '0;
                    end else begin
                        state_d     = ST_FETCH;
                        bram_en_d   = 1'b1;
                        bram_addr_d = '0;
                        rd_cnt_d    = CNT_ONE;
                    end
                end
            end

            ST_LOAD: begin
                if (ld_hs) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b1;
                    bram_addr_d = wr_cnt_q[AW-1:0];
                    bram_di_d   = LD_DATA;
                    if (wr_cnt_q == CNT_LAST) begin
                        state_d  = ST_IDLE;
                        wr_cnt_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end
            end

            ST_FETCH: begin
                if ((rd_cnt_q < CNT_DEPTH) && (occ_next <= 3'd1)) begin
                    bram_en_d   = 1'b1;
                    bram_addr_d = rd_cnt_q[AW-1:0];
                    rd_cnt_d    = rd_cnt_q + CNT_ONE;
                end
                if (fifo_pop && W_LAST) begin
                    state_d  = ST_IDLE;
                    rd_cnt_d = '0;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_di_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_di_q   <= bram_di_d;
            done_q      <= done_d;
        end
    end

    assign BRAM_EN   = bram_en_q;
    assign BRAM_WE   = bram_we_q;
    assign BRAM_ADDR = bram_addr_q;
    assign BRAM_DI   = bram_di_q;
    assign DONE      = done_q;

endmodule
